// File: rtl/sd_pkg.sv
// Shared types and constants for the SD single-block read path.
// Holds the sequencer state encoding and the CMD17 frame builder.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_R1,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_TAIL
    } state_e;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] DUMMY_CRC   = 8'hFF;
    localparam logic [7:0] IDLE_BYTE   = 8'hFF;

    localparam int SECTOR_BYTES = 512;
    localparam int CMD_BYTES    = 6;
    localparam int CRC_BYTES    = 2;

    // Byte idx of the CMD17 frame: opcode, 4 address bytes, CRC.
    function automatic logic [7:0] cmd_byte(
        input logic [2:0]  idx,
        input logic [31:0] addr
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD17;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            default: b = DUMMY_CRC;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte engine: SCLK divider plus 8-bit shifter.
// done is high in the cycle before the last falling edge so the
// sequencer can chain the next byte with no gap on the wire.
module sd_spi_byte #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clr,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       done,
    output logic       rx_stb,
    output logic       sclk,
    output logic       di,
    input  logic       do_i
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic          sclk_q, sclk_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    rx_q, rx_d;
    logic          stb_q, stb_d;
    logic          half;

    assign half   = active_q && (div_q == DIV_LAST);
    assign done   = half && sclk_q && (bit_q == 3'd7);
    assign rx     = rx_q;
    assign rx_stb = stb_q;
    assign sclk   = sclk_q;
    assign di     = sh_q[7];

    // Half-period timing, rising-edge sampling, falling-edge shifting.
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        stb_d    = 1'b0;
        if (clr) begin
            active_d = 1'b0;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            sh_d     = 8'hFF;
        end else begin
            if (active_q) begin
                div_d = div_q + DW'(1);
                if (half) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], do_i};
                        stb_d  = (bit_q == 3'd7);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            active_d = 1'b0;
                            sh_d     = 8'hFF;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            sh_d  = {sh_q[6:0], 1'b1};
                        end
                    end
                end
            end
            if (start) begin
                active_d = 1'b1;
                div_d    = '0;
                bit_d    = '0;
                sh_d     = tx;
            end
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= 8'hFF;
            rx_q     <= 8'h00;
            stb_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            stb_q    <= stb_d;
        end
    end

endmodule

// File: rtl/sd_block_reader.sv
// CMD17 single-block reader with init-engine pin passthrough.
// Sequences one SPI byte at a time and streams 512 sector bytes.
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int CLK_DIV       = 64,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int R1_TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        init_sclk,
    input  logic        init_di,
    input  logic        init_cs,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        rd_err,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        DO,
    output logic        SCLK,
    output logic        DI,
    output logic        CS
);

    localparam logic [15:0] CMD_LAST = 16'(CMD_BYTES - 1);
    localparam logic [15:0] R1_LAST  = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOKEN_TIMEOUT - 1);
    localparam logic [15:0] SEC_LAST = 16'(SECTOR_BYTES - 1);
    localparam logic [15:0] CRC_LAST = 16'(CRC_BYTES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        dv_q, dv_d;
    logic [7:0]  dout_q, dout_d;
    logic        fail;

    logic        spi_start;
    logic        spi_clr;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_done;
    logic        spi_stb;
    logic        spi_sclk;
    logic        spi_di;

    sd_spi_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (spi_start),
        .clr    (spi_clr),
        .tx     (spi_tx),
        .rx     (spi_rx),
        .done   (spi_done),
        .rx_stb (spi_stb),
        .sclk   (spi_sclk),
        .di     (spi_di),
        .do_i   (DO)
    );

    assign SCLK       = init_done ? spi_sclk : init_sclk;
    assign DI         = init_done ? spi_di   : init_di;
    assign CS         = init_done ? cs_q     : init_cs;
    assign rd_busy    = busy_q;
    assign rd_done    = done_q;
    assign rd_err     = err_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;

    // Transaction sequencer: decides the next byte at each byte end.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        dv_d      = 1'b0;
        dout_d    = dout_q;
        spi_start = 1'b0;
        spi_clr   = 1'b0;
        spi_tx    = IDLE_BYTE;
        fail      = 1'b0;
        if (state_q != ST_IDLE && !init_done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            spi_clr = 1'b1;
        end else begin
            if (state_q == ST_DATA && spi_stb) begin
                dv_d   = 1'b1;
                dout_d = spi_rx;
            end
            unique case (state_q)
                ST_IDLE: begin
                    cs_d = 1'b1;
                    if (rd_req && init_done) begin
                        state_d   = ST_CMD;
                        cnt_d     = '0;
                        addr_d    = rd_addr;
                        cs_d      = 1'b0;
                        busy_d    = 1'b1;
                        err_d     = 1'b0;
                        spi_start = 1'b1;
                        spi_tx    = cmd_byte(3'd0, rd_addr);
                    end
                end
                ST_CMD: if (spi_done) begin
                    spi_start = 1'b1;
                    if (cnt_q == CMD_LAST) begin
                        state_d = ST_R1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        spi_tx = cmd_byte(cnt_q[2:0] + 3'd1, addr_q);
                    end
                end
                ST_R1: if (spi_done) begin
                    if (spi_rx == 8'h00) begin
                        state_d   = ST_TOKEN;
                        cnt_d     = '0;
                        spi_start = 1'b1;
                    end else if (spi_rx != IDLE_BYTE) begin
                        fail = 1'b1;
                    end else if (cnt_q == R1_LAST) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 16'd1;
                        spi_start = 1'b1;
                    end
                end
                ST_TOKEN: if (spi_done) begin
                    spi_start = 1'b1;
                    if (spi_rx == TOKEN_START) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else if (spi_rx == IDLE_BYTE) begin
                        if (cnt_q == TOK_LAST) fail = 1'b1;
                        else cnt_d = cnt_q + 16'd1;
                    end else if (spi_rx[7:4] == 4'h0) begin
                        fail = 1'b1;
                    end
                end
                ST_DATA: if (spi_done) begin
                    spi_start = 1'b1;
                    if (cnt_q == SEC_LAST) begin
                        state_d = ST_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_CRC: if (spi_done) begin
                    spi_start = 1'b1;
                    if (cnt_q == CRC_LAST) begin
                        state_d = ST_TAIL;
                        cnt_d   = '0;
                        cs_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_TAIL: if (spi_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (fail) begin
                state_d   = ST_TAIL;
                cnt_d     = '0;
                cs_d      = 1'b1;
                err_d     = 1'b1;
                spi_start = 1'b1;
                spi_tx    = IDLE_BYTE;
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: byte-stream card model on the SPI pins
// plus a byte-level model of the read protocol outcome.
module tb_sd_block_reader;

    localparam int CLK_DIV = 2;
    localparam int TOKEN_TIMEOUT = 64;
    localparam int R1_TIMEOUT = 8;
    localparam int BYTE_T = 16 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        init_sclk = 1'b0;
    logic        init_di = 1'b1;
    logic        init_cs = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_busy, rd_done, rd_err, data_valid;
    logic [7:0]  data_out;
    logic        DO, SCLK, DI, CS;

    sd_block_reader #(
        .CLK_DIV       (CLK_DIV),
        .TOKEN_TIMEOUT (TOKEN_TIMEOUT),
        .R1_TIMEOUT    (R1_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .init_sclk  (init_sclk),
        .init_di    (init_di),
        .init_cs    (init_cs),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .rd_done    (rd_done),
        .rd_err     (rd_err),
        .data_out   (data_out),
        .data_valid (data_valid),
        .DO         (DO),
        .SCLK       (SCLK),
        .DI         (DI),
        .CS         (CS)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Card: bytes it shifts out, and bytes captured from DI.
    logic [7:0] resp [0:1023];
    logic [7:0] mosi [0:1023];
    int rcnt = 0;

    assign DO = resp[(rcnt >> 3) & 1023][7 - (rcnt & 7)];

    always @(posedge SCLK) begin
        if (init_done) begin
            mosi[(rcnt >> 3) & 1023] = {mosi[(rcnt >> 3) & 1023][6:0], DI};
            rcnt = rcnt + 1;
        end
    end

    // Output monitor.
    int cyc = 0;
    int dv_cnt = 0;
    int last_dv = 0;
    int bad_gap = 0;
    int done_cnt = 0;
    logic [7:0] dv_q [$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_cnt > 0 && (cyc - last_dv) != BYTE_T)
                bad_gap = bad_gap + 1;
            last_dv = cyc;
            dv_cnt = dv_cnt + 1;
            dv_q.push_back(data_out);
        end
        if (rd_done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Response stream: 6 idle bytes under CMD, p1 FF, R1, p2 FF,
    // token, 512 data bytes, 2 CRC bytes, idle fill.
    task automatic fill(input int p1, input logic [7:0] r1,
                        input int p2, input logic [7:0] tok,
                        input bit rnd);
        int k;
        for (int i = 0; i < 1024; i++) resp[i] = 8'hFF;
        k = 6 + p1;
        resp[k] = r1;
        k = k + 1 + p2;
        resp[k] = tok;
        k = k + 1;
        for (int j = 0; j < 512; j++)
            resp[k + j] = rnd ? 8'($urandom) : 8'(j);
        resp[k + 512] = 8'($urandom);
        resp[k + 513] = 8'($urandom);
    endtask

    // Outcome of a read from the card's byte stream alone.
    function automatic void model(output bit err, output int nbytes,
                                  output int dbase);
        int k;
        int polls;
        logic [7:0] b;
        k = 6;
        polls = 0;
        err = 1'b0;
        dbase = 0;
        while (1) begin
            b = resp[k];
            k++;
            if (b != 8'hFF) begin
                if (b != 8'h00) err = 1'b1;
                break;
            end
            polls++;
            if (polls == R1_TIMEOUT) begin
                err = 1'b1;
                break;
            end
        end
        polls = 0;
        while (!err) begin
            b = resp[k];
            k++;
            if (b == 8'hFE) break;
            if (b == 8'hFF) begin
                polls++;
                if (polls == TOKEN_TIMEOUT) err = 1'b1;
            end else if (b[7:4] == 4'h0) begin
                err = 1'b1;
            end
        end
        if (!err) begin
            dbase = k;
            k = k + 514;
        end
        nbytes = k + 1;
    endfunction

    task automatic start_read(input logic [31:0] addr);
        step();
        rcnt = 0;
        dv_cnt = 0;
        bad_gap = 0;
        done_cnt = 0;
        dv_q.delete();
        rd_addr = addr;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr);
        bit exp_err;
        int nb;
        int dbase;
        int t0;
        int w;
        int bad;
        int nexp;
        logic [7:0] ecmd [6];
        model(exp_err, nb, dbase);
        nexp = exp_err ? 0 : 512;
        start_read(addr);
        t0 = cyc;
        chk({tag, " busy"}, 32'(rd_busy), 32'd1);
        w = 0;
        while (!rd_done && w < (nb + 4) * BYTE_T) begin
            step();
            w++;
        end
        chk({tag, " done_seen"}, 32'(rd_done), 32'd1);
        w = cyc - t0 - nb * BYTE_T;
        chk({tag, " latency"}, 32'(w >= -2 && w <= 2), 32'd1);
        chk({tag, " err"}, 32'(rd_err), 32'(exp_err));
        chk({tag, " cs_high"}, 32'(CS), 32'd1);
        chk({tag, " bits"}, 32'(rcnt), 32'(nb * 8));
        chk({tag, " strobes"}, 32'(dv_cnt), 32'(nexp));
        chk({tag, " gaps"}, 32'(bad_gap), 32'd0);
        bad = 0;
        for (int i = 0; i < dv_q.size() && i < nexp; i++)
            if (dv_q[i] !== resp[dbase + i]) bad++;
        chk({tag, " data"}, 32'(bad), 32'd0);
        ecmd = '{8'h51, addr[31:24], addr[23:16],
                 addr[15:8], addr[7:0], 8'hFF};
        for (int i = 0; i < 6; i++)
            chk({tag, " cmd_byte"}, 32'(mosi[i]), 32'(ecmd[i]));
        bad = 0;
        for (int i = 6; i < nb; i++)
            if (mosi[i] !== 8'hFF) bad++;
        chk({tag, " di_idle"}, 32'(bad), 32'd0);
        step();
        chk({tag, " done_pulse"}, 32'(rd_done), 32'd0);
        chk({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, " idle_busy"}, 32'(rd_busy), 32'd0);
        chk({tag, " err_hold"}, 32'(rd_err), 32'(exp_err));
    endtask

    initial begin
        int w;
        logic [2:0] pins;
        for (int i = 0; i < 1024; i++) begin
            resp[i] = 8'hFF;
            mosi[i] = 8'hFF;
        end
        #23;
        chk("rst busy", 32'(rd_busy), 32'd0);
        chk("rst done", 32'(rd_done), 32'd0);
        chk("rst err", 32'(rd_err), 32'd0);
        chk("rst dv", 32'(data_valid), 32'd0);
        chk("rst dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        step();

        // Pre-init passthrough; requests are ignored.
        for (int i = 0; i < 6; i++) begin
            pins = 3'($urandom);
            {init_sclk, init_di, init_cs} = pins;
            #1;
            chk("pass pins", 32'({SCLK, DI, CS}), 32'(pins));
        end
        rd_req = 1'b1;
        step();
        step();
        rd_req = 1'b0;
        chk("pre busy", 32'(rd_busy), 32'd0);
        init_done = 1'b1;
        #1;
        chk("own sclk", 32'(SCLK), 32'd0);
        chk("own di", 32'(DI), 32'd1);
        chk("own cs", 32'(CS), 32'd1);

        fill(2, 8'h00, 10, 8'hFE, 1'b0);
        do_read("good", 32'h0000_1234);

        fill($urandom_range(0, R1_TIMEOUT - 1), 8'h00,
             $urandom_range(0, 20), 8'hFE, 1'b1);
        do_read("rand", $urandom);

        fill(1, 8'h04, 3, 8'hFE, 1'b0);
        do_read("r1err", 32'hDEAD_BEEF);

        fill(R1_TIMEOUT, 8'h00, 0, 8'hFE, 1'b0);
        do_read("r1tmo", 32'h0000_0007);

        fill(1, 8'h00, TOKEN_TIMEOUT, 8'hFE, 1'b0);
        do_read("toktmo", 32'h0102_0304);

        fill(0, 8'h00, 3, 8'h08, 1'b0);
        do_read("errtok", 32'h00AB_CDEF);

        // Drop init_done after the 100th sector byte.
        fill(1, 8'h00, 2, 8'hFE, 1'b0);
        start_read(32'h0000_0042);
        w = 0;
        while (dv_cnt < 100 && w < 200 * BYTE_T) begin
            step();
            w++;
        end
        chk("abort reach", 32'(dv_cnt), 32'd100);
        init_done = 1'b0;
        {init_sclk, init_di, init_cs} = 3'b101;
        step();
        chk("abort done", 32'(rd_done), 32'd1);
        chk("abort err", 32'(rd_err), 32'd1);
        chk("abort busy", 32'(rd_busy), 32'd0);
        chk("abort pins", 32'({SCLK, DI, CS}), 32'b101);
        for (int i = 0; i < 3 * BYTE_T; i++) step();
        chk("abort strobes", 32'(dv_cnt), 32'd100);
        chk("abort done_cnt", 32'(done_cnt), 32'd1);
        init_done = 1'b1;
        #1;
        chk("abort cs", 32'(CS), 32'd1);
        chk("abort sclk", 32'(SCLK), 32'd0);

        // Asynchronous reset in the middle of the command frame.
        start_read(32'h5555_AAAA);
        for (int i = 0; i < 3 * BYTE_T; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(rd_busy), 32'd0);
        chk("arst cs", 32'(CS), 32'd1);
        chk("arst sclk", 32'(SCLK), 32'd0);
        chk("arst di", 32'(DI), 32'd1);
        chk("arst dout", 32'(data_out), 32'd0);
        chk("arst flags", 32'({rd_done, rd_err, data_valid}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst no_done", 32'(done_cnt), 32'd0);

        fill(3, 8'h00, 5, 8'hFE, 1'b1);
        do_read("post_rst", 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
